// File: rtl/lr35902_vram_dp_if.sv
// Bus bundle for the LR35902 VRAM: CPU read/write port, PPU read port, lock and drop counter.
// Purely wiring; carries no state or latency of its own.
// Strobe-based handshake: accesses are edge-triggered and completed by one-cycle acks.
interface lr35902_vram_dp_if #(
  parameter int ADR_WIDTH  = 13,
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) ();
  logic [ADR_WIDTH-1:0]  cpu_adr;
  logic [BANK_BITS-1:0]  cpu_bank;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  cpu_read;
  logic                  cpu_write;
  logic                  cpu_ack;
  logic [ADR_WIDTH-1:0]  ppu_adr;
  logic [BANK_BITS-1:0]  ppu_bank;
  logic [DATA_WIDTH-1:0] ppu_dout;
  logic                  ppu_read;
  logic                  ppu_ack;
  logic                  lock;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  // Requester side (CPU/PPU/mode logic)
  modport master (
    output cpu_adr, cpu_bank, cpu_din, cpu_read, cpu_write,
    output ppu_adr, ppu_bank, ppu_read, lock,
    input  cpu_dout, cpu_ack, ppu_dout, ppu_ack, drop_cnt
  );

  // VRAM side
  modport slave (
    input  cpu_adr, cpu_bank, cpu_din, cpu_read, cpu_write,
    input  ppu_adr, ppu_bank, ppu_read, lock,
    output cpu_dout, cpu_ack, ppu_dout, ppu_ack, drop_cnt
  );
endinterface

// File: rtl/lr35902_vram_dp.sv
// Bank-switched dual-port VRAM: CPU read/write port plus independent PPU read port, CPU lockout.
// Latency: 1 cycle from strobe edge to dout/ack on either port.
// No backpressure: one access per port per strobe edge; locked CPU reads return FILL, writes are dropped and counted.
module lr35902_vram_dp #(
  parameter int                    ADR_WIDTH  = 13,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    BANK_BITS  = 1,
  parameter logic [DATA_WIDTH-1:0] FILL       = {DATA_WIDTH{1'b1}},
  parameter int                    CNT_WIDTH  = 8
) (
  input logic                clk,
  input logic                reset,
  lr35902_vram_dp_if.slave   bus
);
  localparam int WORD_BITS = ADR_WIDTH + BANK_BITS;
  localparam int DEPTH     = 2 ** WORD_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_cpu_read;
  logic                  r_cpu_write;
  logic                  r_ppu_read;
  logic [DATA_WIDTH-1:0] r_cpu_dout;
  logic [DATA_WIDTH-1:0] r_ppu_dout;
  logic                  r_cpu_ack;
  logic                  r_ppu_ack;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

  logic                  w_cpu_rd_ev;
  logic                  w_cpu_wr_ev;
  logic                  w_ppu_rd_ev;
  logic [WORD_BITS-1:0]  w_cpu_word;
  logic [WORD_BITS-1:0]  w_ppu_word;

  // Events are suppressed in reset cycles so nothing is committed or acked while reset is high
  assign w_cpu_rd_ev = bus.cpu_read  & ~r_cpu_read  & ~reset;
  assign w_cpu_wr_ev = ~bus.cpu_write & r_cpu_write & ~reset;
  assign w_ppu_rd_ev = bus.ppu_read  & ~r_ppu_read  & ~reset;
  assign w_cpu_word  = {bus.cpu_bank, bus.cpu_adr};
  assign w_ppu_word  = {bus.ppu_bank, bus.ppu_adr};

  assign bus.cpu_dout = r_cpu_dout;
  assign bus.ppu_dout = r_ppu_dout;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.ppu_ack  = r_ppu_ack;
  assign bus.drop_cnt = r_drop_cnt;

  // Strobe history: tracked through reset so a strobe held across reset release gives no edge
  always_ff @(posedge clk) begin
    r_cpu_read  <= bus.cpu_read;
    r_cpu_write <= bus.cpu_write;
    r_ppu_read  <= bus.ppu_read;
  end

  // Storage write on unlocked CPU write falling edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_cpu_wr_ev && !bus.lock) begin
      r_mem[w_cpu_word] <= bus.cpu_din;
    end
  end

  // Read data, acks and drop counter; same-cycle reads see pre-write contents
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_dout <= '0;
      r_ppu_dout <= '0;
      r_cpu_ack  <= 1'b0;
      r_ppu_ack  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_cpu_ack <= w_cpu_rd_ev | w_cpu_wr_ev;
      r_ppu_ack <= w_ppu_rd_ev;
      if (w_cpu_rd_ev) begin
        r_cpu_dout <= bus.lock ? FILL : r_mem[w_cpu_word];
      end
      if (w_cpu_wr_ev && bus.lock && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_ppu_rd_ev) begin
        r_ppu_dout <= r_mem[w_ppu_word];
      end
    end
  end
endmodule

// File: tb/tb_lr35902_vram_dp.sv
// Directed bench for lr35902_vram_dp: default instance plus a CNT_WIDTH=2 instance for saturation.
// Inputs driven 1 time unit after posedge, outputs sampled at the same point or on negedge.
// Ack pulses are counted on negedge to catch missing or extra acks.
module tb_lr35902_vram_dp;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cpu_acks;
  int   ppu_acks;
  int   base;
  logic [7:0] model [16];

  lr35902_vram_dp_if bus ();
  lr35902_vram_dp_if #(.CNT_WIDTH(2)) bus2 ();

  lr35902_vram_dp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  lr35902_vram_dp #(.CNT_WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ack pulse counters for the default instance
  always @(negedge clk) begin
    if (bus.cpu_ack) cpu_acks++;
    if (bus.ppu_ack) ppu_acks++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic bank, input logic [12:0] adr, input logic [7:0] din);
    bus.cpu_bank  = bank;
    bus.cpu_adr   = adr;
    bus.cpu_din   = din;
    bus.cpu_write = 1'b1;
    tick();
    tick();
    bus.cpu_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic cpu_rd(input logic bank, input logic [12:0] adr);
    bus.cpu_bank = bank;
    bus.cpu_adr  = adr;
    bus.cpu_read = 1'b1;
    tick();
    bus.cpu_read = 1'b0;
  endtask

  task automatic ppu_rd(input logic bank, input logic [12:0] adr);
    bus.ppu_bank = bank;
    bus.ppu_adr  = adr;
    bus.ppu_read = 1'b1;
    tick();
    bus.ppu_read = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cpu_acks = 0; ppu_acks = 0;
    reset = 1'b1;
    bus.cpu_adr = '0; bus.cpu_bank = '0; bus.cpu_din = '0;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    bus.ppu_adr = '0; bus.ppu_bank = '0; bus.ppu_read = 1'b0; bus.lock = 1'b0;
    bus2.cpu_adr = '0; bus2.cpu_bank = '0; bus2.cpu_din = '0;
    bus2.cpu_read = 1'b0; bus2.cpu_write = 1'b0;
    bus2.ppu_adr = '0; bus2.ppu_bank = '0; bus2.ppu_read = 1'b0; bus2.lock = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_cpu_dout", bus.cpu_dout, 0);
    check("rst_ppu_dout", bus.ppu_dout, 0);
    check("rst_acks", {bus.cpu_ack, bus.ppu_ack}, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);

    // Basic write then read
    base = cpu_acks;
    cpu_wr(1'b0, 13'h0010, 8'hA5);
    cpu_rd(1'b0, 13'h0010);
    check("rd_ack_pulse", bus.cpu_ack, 1);
    check("rd_a5", bus.cpu_dout, 8'hA5);
    tick();
    check("rd_ack_low", bus.cpu_ack, 0);
    check("wr_rd_ack_count", cpu_acks - base, 2);

    // Bank isolation at the top word of each bank
    cpu_wr(1'b0, 13'h1FFF, 8'h11);
    cpu_wr(1'b1, 13'h1FFF, 8'h22);
    ppu_rd(1'b0, 13'h1FFF);
    check("ppu_ack_pulse", bus.ppu_ack, 1);
    check("bank0_top", bus.ppu_dout, 8'h11);
    tick();
    ppu_rd(1'b1, 13'h1FFF);
    check("bank1_top", bus.ppu_dout, 8'h22);
    tick();
    cpu_rd(1'b1, 13'h1FFF);
    check("cpu_bank1_top", bus.cpu_dout, 8'h22);
    tick();

    // Lockout: fill on read, dropped writes counted, RAM untouched
    bus.lock = 1'b1;
    cpu_rd(1'b0, 13'h0010);
    check("lock_rd_ack", bus.cpu_ack, 1);
    check("lock_rd_fill", bus.cpu_dout, 8'hFF);
    tick();
    for (int i = 0; i < 3; i++) cpu_wr(1'b0, 13'h1FFF, 8'h5A);
    check("drop_cnt_3", bus.drop_cnt, 3);
    ppu_rd(1'b0, 13'h1FFF);
    check("lock_ppu_reads", bus.ppu_dout, 8'h11);
    tick();
    bus.lock = 1'b0;
    cpu_rd(1'b0, 13'h1FFF);
    check("unlock_ram_kept", bus.cpu_dout, 8'h11);
    tick();

    // Saturation of a 2-bit drop counter
    bus2.lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.cpu_write = 1'b1;
      tick();
      bus2.cpu_write = 1'b0;
      tick();
      if (i == 2) check("sat_reach_3", bus2.drop_cnt, 3);
    end
    check("sat_hold_3", bus2.drop_cnt, 3);

    // Same-cycle CPU write and PPU read to one word
    cpu_wr(1'b0, 13'h0040, 8'h01);
    bus.cpu_adr = 13'h0040; bus.cpu_bank = 1'b0; bus.cpu_din = 8'h02;
    bus.cpu_write = 1'b1;
    tick();
    bus.cpu_write = 1'b0;
    ppu_rd(1'b0, 13'h0040);
    check("coll_ppu_old", bus.ppu_dout, 8'h01);
    tick();
    ppu_rd(1'b0, 13'h0040);
    check("coll_ppu_new", bus.ppu_dout, 8'h02);
    tick();

    // Same-cycle CPU read and write to one word: old data, single ack
    base = cpu_acks;
    bus.cpu_din = 8'h03;
    bus.cpu_write = 1'b1;
    tick();
    bus.cpu_write = 1'b0;
    cpu_rd(1'b0, 13'h0040);
    check("rdwr_old_data", bus.cpu_dout, 8'h02);
    tick();
    check("rdwr_single_ack", cpu_acks - base, 1);
    ppu_rd(1'b0, 13'h0040);
    check("rdwr_write_done", bus.ppu_dout, 8'h03);
    tick();

    // Back-to-back PPU reads with random CPU writes
    for (int i = 0; i < 16; i++) begin
      cpu_wr(1'b0, 13'(i), 8'(8'h30 + i));
      model[i] = 8'(8'h30 + i);
    end
    base = ppu_acks;
    for (int i = 0; i < 16; i++) begin
      logic       do_wr;
      logic [3:0] wa;
      logic [7:0] wd;
      do_wr = 1'($urandom_range(0, 1));
      wa    = 4'($urandom_range(0, 15));
      wd    = 8'($urandom_range(0, 255));
      bus.ppu_bank = 1'b0;
      bus.ppu_adr  = 13'(i);
      bus.ppu_read = 1'b1;
      bus.cpu_bank = 1'b0;
      bus.cpu_adr  = 13'(wa);
      bus.cpu_din  = wd;
      bus.cpu_write = do_wr;
      tick();
      check($sformatf("b2b_ppu_%0d", i), bus.ppu_dout, model[i]);
      bus.ppu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      tick();
      if (do_wr) model[wa] = wd;
    end
    tick();
    check("b2b_ppu_ack_count", ppu_acks - base, 16);

    // Strobes held high through reset release give no edge
    reset = 1'b1;
    bus.cpu_read = 1'b1;
    bus.ppu_read = 1'b1;
    tick();
    tick();
    base = cpu_acks + ppu_acks;
    reset = 1'b0;
    repeat (3) tick();
    check("held_no_ack", cpu_acks + ppu_acks - base, 0);
    check("held_cpu_dout", bus.cpu_dout, 0);
    check("held_ppu_dout", bus.ppu_dout, 0);
    bus.cpu_read = 1'b0;
    bus.ppu_read = 1'b0;
    tick();

    // Read edge coinciding with reset assertion is cancelled
    base = cpu_acks;
    reset = 1'b1;
    bus.cpu_read = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_edge_no_ack", cpu_acks - base, 0);
    check("rst_edge_dout", bus.cpu_dout, 0);
    bus.cpu_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
